// File: rtl/seven_seg_scan_ctrl.sv
// Eight-digit common-anode seven-segment scan controller with a double-buffered display image.
// Optional build macro SEVSEG_GHOST_BLANK_EN blanks the first BLANK_CYCLES cycles of every digit slot.
module seven_seg_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] digits,
   input  logic [7:0]  digit_en,
   input  logic [7:0]  dp,
   input  logic        load,
   output logic [2:0]  sel,
   output logic [7:0]  anode,
   output logic [6:0]  cathode,
   output logic        dp_n,
   output logic        frame_done
);

   localparam int PW = $clog2(REFRESH_DIV);

   typedef struct packed {
      logic [31:0] digits;
      logic [7:0]  en;
      logic [7:0]  dp;
   } image_t;

   if (REFRESH_DIV < 2 || REFRESH_DIV > (1 << 24)) begin : g_bad_div
      $error("REFRESH_DIV must lie in 2..2^24");
   end
   if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
      $error("BLANK_CYCLES must be smaller than REFRESH_DIV");
   end

   logic [PW-1:0] prescaler;
   image_t        shadow;
   image_t        active;
   logic          tick;
   logic          wrap;
   logic          blank;
   logic [3:0]    nibble;
   logic [7:0]    anode_next;
   logic [6:0]    cathode_next;
   logic          dp_n_next;

   assign tick = (prescaler == PW'(REFRESH_DIV - 1));
   assign wrap = tick && (sel == 3'd7);

`ifdef SEVSEG_GHOST_BLANK_EN
   assign blank = (prescaler < PW'(BLANK_CYCLES));
`else
   assign blank = 1'b0;
`endif

   assign nibble = active.digits[{sel, 2'b00} +: 4];

   // Drive for the current slot; registered below so outputs trail sel by one cycle.
   always_comb begin
      anode_next   = 8'hFF;
      cathode_next = 7'h7F;
      dp_n_next    = 1'b1;
      if (active.en[sel] && !blank) begin
         anode_next = ~(8'h01 << sel);
         dp_n_next  = ~active.dp[sel];
         case (nibble)
            4'h0: cathode_next = 7'b1000000;
            4'h1: cathode_next = 7'b1111001;
            4'h2: cathode_next = 7'b0100100;
            4'h3: cathode_next = 7'b0110000;
            4'h4: cathode_next = 7'b0011001;
            4'h5: cathode_next = 7'b0010010;
            4'h6: cathode_next = 7'b0000010;
            4'h7: cathode_next = 7'b1111000;
            4'h8: cathode_next = 7'b0000000;
            4'h9: cathode_next = 7'b0010000;
            4'hA: cathode_next = 7'b0001000;
            4'hB: cathode_next = 7'b0000011;
            4'hC: cathode_next = 7'b1000110;
            4'hD: cathode_next = 7'b0100001;
            4'hE: cathode_next = 7'b0000110;
            default: cathode_next = 7'b0001110;
         endcase
      end
   end

   // The active image only changes on the 7->0 tick, so a frame is never torn;
   // a load on that same edge lands in shadow and waits for the next frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler  <= '0;
         sel        <= 3'd0;
         shadow     <= '0;
         active     <= '0;
         anode      <= 8'hFF;
         cathode    <= 7'h7F;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         prescaler  <= tick ? '0 : prescaler + 1'b1;
         if (tick) begin
            sel <= sel + 3'd1;
         end
         if (load) begin
            shadow <= '{digits: digits, en: digit_en, dp: dp};
         end
         if (wrap) begin
            active <= shadow;
         end
         frame_done <= wrap;
         anode      <= anode_next;
         cathode    <= cathode_next;
         dp_n       <= dp_n_next;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: directed scenarios plus random loads,
// compared every cycle against a frame-level arithmetic model.
module tb_seven_seg_scan_ctrl;

`ifdef SEVSEG_GHOST_BLANK_EN
   localparam int R = 8;
`else
   localparam int R = 4;
`endif
   localparam int B = 2;
   localparam int FRAME = 8 * R;

   localparam logic [6:0] SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] digits;
   logic [7:0]  digit_en;
   logic [7:0]  dp;
   logic        load;
   logic [2:0]  sel;
   logic [7:0]  anode;
   logic [6:0]  cathode;
   logic        dp_n;
   logic        frame_done;

   int vectors = 0;
   int miscompares = 0;

   // Model state: cycles since reset, shadow/active images, expected outputs.
   int unsigned c;
   logic [31:0] sh_dig, ac_dig;
   logic [7:0]  sh_en, ac_en, sh_dp, ac_dp;
   logic [2:0]  e_sel;
   logic [7:0]  e_anode;
   logic [6:0]  e_cathode;
   logic        e_dp_n;
   logic        e_fd;

   seven_seg_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst_n(rst_n), .digits(digits), .digit_en(digit_en), .dp(dp),
      .load(load), .sel(sel), .anode(anode), .cathode(cathode), .dp_n(dp_n),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic modelEdge();
      int s;
      int p;
      logic wrap;
      logic blank;
      if (!rst_n) begin
         c = 0;
         sh_dig = '0; sh_en = '0; sh_dp = '0;
         ac_dig = '0; ac_en = '0; ac_dp = '0;
         e_anode = 8'hFF; e_cathode = 7'h7F; e_dp_n = 1'b1; e_fd = 1'b0;
      end else begin
         s = (c / R) % 8;
         p = c % R;
         wrap = (((c + 1) % FRAME) == 0);
         blank = 1'b0;
`ifdef SEVSEG_GHOST_BLANK_EN
         blank = (p < B);
`endif
         if (ac_en[s] && !blank) begin
            e_anode = 8'hFF;
            e_anode[s] = 1'b0;
            e_cathode = SEG[(ac_dig >> (4 * s)) & 32'hF];
            e_dp_n = ~ac_dp[s];
         end else begin
            e_anode = 8'hFF; e_cathode = 7'h7F; e_dp_n = 1'b1;
         end
         e_fd = wrap;
         if (wrap) begin
            ac_dig = sh_dig; ac_en = sh_en; ac_dp = sh_dp;
         end
         if (load) begin
            sh_dig = digits; sh_en = digit_en; sh_dp = dp;
         end
         c++;
      end
      e_sel = 3'((c / R) % 8);
   endtask

   task automatic checkOutput();
      vectors++;
      assert (sel === e_sel) else begin
         miscompares++;
         $error("[TB] FAIL sel @c=%0d: observed %0d expected %0d", c, sel, e_sel);
      end
      vectors++;
      assert (anode === e_anode) else begin
         miscompares++;
         $error("[TB] FAIL anode @c=%0d: observed %h expected %h", c, anode, e_anode);
      end
      vectors++;
      assert (cathode === e_cathode) else begin
         miscompares++;
         $error("[TB] FAIL cathode @c=%0d: observed %b expected %b", c, cathode, e_cathode);
      end
      vectors++;
      assert (dp_n === e_dp_n) else begin
         miscompares++;
         $error("[TB] FAIL dp_n @c=%0d: observed %b expected %b", c, dp_n, e_dp_n);
      end
      vectors++;
      assert (frame_done === e_fd) else begin
         miscompares++;
         $error("[TB] FAIL frame_done @c=%0d: observed %b expected %b", c, frame_done, e_fd);
      end
   endtask

   // Drive one cycle of inputs, clock it, update the model and compare.
   task automatic applyStimulus(input logic rst_v, input logic load_v,
                                input logic [31:0] dig_v, input logic [7:0] en_v,
                                input logic [7:0] dp_v);
      rst_n = rst_v; load = load_v; digits = dig_v; digit_en = en_v; dp = dp_v;
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, $urandom, 8'($urandom), 8'($urandom));
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; digits = '0; digit_en = '0; dp = '0;

      $display("[TB] reset hold");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 8'h00, 8'h00);
      idle(R + 2);

      $display("[TB] full scan 76543210");
      applyStimulus(1'b1, 1'b1, 32'h7654_3210, 8'hFF, 8'h00);
      idle(2 * FRAME + 3);

      $display("[TB] blanked digit 2 and dp on digit 0");
      applyStimulus(1'b1, 1'b1, $urandom, 8'b1111_1011, 8'h01);
      idle(2 * FRAME);

      $display("[TB] tearing: load while sel=3");
      applyStimulus(1'b1, 1'b1, 32'h7654_3210, 8'hFF, 8'h00);
      idle(FRAME);
      for (int i = 0; i < FRAME && e_sel != 3'd3; i++) idle(1);
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 8'hFF, 8'h00);
      idle(2 * FRAME);

      $display("[TB] coincident load and wrap");
      for (int i = 0; i < FRAME && ((c + 1) % FRAME) != 0; i++) idle(1);
      applyStimulus(1'b1, 1'b1, 32'hA5C3_9E1B, 8'hFF, 8'hAA);
      idle(2 * FRAME + 2);

      $display("[TB] random loads");
      for (int i = 0; i < 6 * FRAME; i++) begin
         applyStimulus(1'b1, ($urandom_range(0, 7) == 0), $urandom,
                       8'($urandom), 8'($urandom));
      end

      $display("[TB] mid-frame reset pulse");
      applyStimulus(1'b1, 1'b1, $urandom, 8'hFF, 8'($urandom));
      idle(FRAME + 3 * R + 1);
      applyStimulus(1'b0, 1'b1, $urandom, 8'hFF, 8'hFF);
      idle(2 * FRAME);
      applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 8'h7F, 8'h81);
      idle(2 * FRAME);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
